// File: rtl/modaddsub_ctrl.sv
// Arbiter and sequencer for the shared modular add/sub datapath: grants one of two
// requesters, drives operand-mux select and op, waits SETTLE cycles, returns the result.
// Optional per-requester handshake counters when MODADDSUB_CTRL_STATS_EN is defined.
module modaddsub_ctrl #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic             req0_op,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic             req1_op,
  output logic             req1_ready,
  output logic             dp_sel,
  output logic             dp_op,
  input  logic [WIDTH-1:0] dp_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             busy
`ifdef MODADDSUB_CTRL_STATS_EN
  ,
  output logic [7:0]       stat0,
  output logic [7:0]       stat1
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_RESP} state_e;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic             op_q, op_d;
  logic             prio_q, prio_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             grant;
  logic             accept;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      sel_q        <= 1'b0;
      op_q         <= 1'b0;
      prio_q       <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      op_q         <= op_d;
      prio_q       <= prio_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    op_d         = op_q;
    prio_d       = prio_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    grant        = 1'b0;
    accept       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req0_valid || req1_valid) begin
          // Round-robin pointer only matters when both requesters contend
          grant   = (req0_valid && req1_valid) ? prio_q : req1_valid;
          sel_d   = grant;
          op_d    = grant ? req1_op : req0_op;
          cnt_d   = CNT_INIT;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          accept       = 1'b1;
          rsp_result_d = dp_result;
          rsp_id_d     = sel_q;
          state_d      = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          prio_d  = ~sel_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Suppress the accept pulse while reset is asserted: that operation is being discarded
  assign req0_ready = accept & ~sel_q & rst_n;
  assign req1_ready = accept &  sel_q & rst_n;
  assign dp_sel     = sel_q;
  assign dp_op      = op_q;
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign busy       = (state_q != ST_IDLE);

`ifdef MODADDSUB_CTRL_STATS_EN
  logic [7:0] stat_q [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_stat
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          stat_q[gi] <= 8'd0;
        end else if (rsp_valid && rsp_ready && (rsp_id_q == 1'(gi)) && (stat_q[gi] != 8'hFF)) begin
          stat_q[gi] <= stat_q[gi] + 8'd1;
        end
      end
    end
  endgenerate

  assign stat0 = stat_q[0];
  assign stat1 = stat_q[1];
`endif

endmodule

// File: tb/tb_modaddsub_ctrl.sv
// Directed bench for modaddsub_ctrl: one task per scenario, inline checks, fixed datapath results.
// Stats checks are compiled in when MODADDSUB_CTRL_STATS_EN is defined.
module tb_modaddsub_ctrl;
  localparam int WIDTH  = 4;
  localparam int SETTLE = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req0_op, req0_ready;
  logic             req1_valid, req1_op, req1_ready;
  logic             dp_sel, dp_op;
  logic [WIDTH-1:0] dp_result;
  logic             rsp_valid, rsp_ready, rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic             busy;
`ifdef MODADDSUB_CTRL_STATS_EN
  logic [7:0]       stat0, stat1;
`endif

  // Datapath stand-in: a fixed result per requester, steered by the operand-mux select
  logic [WIDTH-1:0] res0, res1;
  assign dp_result = dp_sel ? res1 : res0;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  modaddsub_ctrl #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_op    (req0_op),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_op    (req1_op),
    .req1_ready (req1_ready),
    .dp_sel     (dp_sel),
    .dp_op      (dp_op),
    .dp_result  (dp_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .busy       (busy)
`ifdef MODADDSUB_CTRL_STATS_EN
    ,
    .stat0      (stat0),
    .stat1      (stat1)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req0_valid = 1'b0; req0_op = 1'b0; req1_valid = 1'b0; req1_op = 1'b0;
    rsp_ready = 1'b0; res0 = 4'h0; res1 = 4'h0;
    repeat (3) tick();
    total_cnt++; if (req0_ready !== 1'b0) $display("FAIL rst_req0_ready got %b exp 0", req0_ready); else pass_cnt++;
    total_cnt++; if (req1_ready !== 1'b0) $display("FAIL rst_req1_ready got %b exp 0", req1_ready); else pass_cnt++;
    total_cnt++; if (dp_sel !== 1'b0) $display("FAIL rst_dp_sel got %b exp 0", dp_sel); else pass_cnt++;
    total_cnt++; if (dp_op !== 1'b0) $display("FAIL rst_dp_op got %b exp 0", dp_op); else pass_cnt++;
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); else pass_cnt++;
    total_cnt++; if (rsp_id !== 1'b0) $display("FAIL rst_rsp_id got %b exp 0", rsp_id); else pass_cnt++;
    total_cnt++; if (rsp_result !== 4'h0) $display("FAIL rst_rsp_result got %h exp 0", rsp_result); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else pass_cnt++;
    rst_n = 1'b1;
    tick();
    $display("reset: outputs checked at reset values");
  endtask

  task automatic test_single_add();
    res0 = 4'h1; req0_valid = 1'b1; req0_op = 1'b0;
    tick(); // cycle 1
    total_cnt++; if (dp_sel !== 1'b0) $display("FAIL add_dp_sel got %b exp 0", dp_sel); else pass_cnt++;
    total_cnt++; if (dp_op !== 1'b0) $display("FAIL add_dp_op got %b exp 0", dp_op); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL add_busy got %b exp 1", busy); else pass_cnt++;
    total_cnt++; if (req0_ready !== 1'b0) $display("FAIL add_ready_c1 got %b exp 0", req0_ready); else pass_cnt++;
    tick(); // cycle 2
    total_cnt++; if (req0_ready !== 1'b1) $display("FAIL add_ready_c2 got %b exp 1", req0_ready); else pass_cnt++;
    total_cnt++; if (req1_ready !== 1'b0) $display("FAIL add_other_ready got %b exp 0", req1_ready); else pass_cnt++;
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL add_rsp_early got %b exp 0", rsp_valid); else pass_cnt++;
    tick(); // cycle 3
    req0_valid = 1'b0;
    total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL add_rsp_valid got %b exp 1", rsp_valid); else pass_cnt++;
    total_cnt++; if (rsp_id !== 1'b0) $display("FAIL add_rsp_id got %b exp 0", rsp_id); else pass_cnt++;
    total_cnt++; if (rsp_result !== 4'h1) $display("FAIL add_rsp_result got %h exp 1", rsp_result); else pass_cnt++;
    total_cnt++; if (req0_ready !== 1'b0) $display("FAIL add_ready_c3 got %b exp 0", req0_ready); else pass_cnt++;
    rsp_ready = 1'b1;
    tick(); // cycle 4
    rsp_ready = 1'b0;
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL add_rsp_done got %b exp 0", rsp_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL add_idle got %b exp 0", busy); else pass_cnt++;
    $display("single_add: id=%b result=%h", rsp_id, rsp_result);
  endtask

  task automatic test_subtract();
    res1 = 4'hE; req1_valid = 1'b1; req1_op = 1'b1;
    tick(); // cycle 1
    total_cnt++; if (dp_sel !== 1'b1) $display("FAIL sub_dp_sel got %b exp 1", dp_sel); else pass_cnt++;
    total_cnt++; if (dp_op !== 1'b1) $display("FAIL sub_dp_op got %b exp 1", dp_op); else pass_cnt++;
    tick(); // cycle 2
    total_cnt++; if (req1_ready !== 1'b1) $display("FAIL sub_ready got %b exp 1", req1_ready); else pass_cnt++;
    total_cnt++; if (req0_ready !== 1'b0) $display("FAIL sub_other_ready got %b exp 0", req0_ready); else pass_cnt++;
    tick(); // cycle 3
    req1_valid = 1'b0;
    total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL sub_rsp_valid got %b exp 1", rsp_valid); else pass_cnt++;
    total_cnt++; if (rsp_id !== 1'b1) $display("FAIL sub_rsp_id got %b exp 1", rsp_id); else pass_cnt++;
    total_cnt++; if (rsp_result !== 4'hE) $display("FAIL sub_rsp_result got %h exp e", rsp_result); else pass_cnt++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    total_cnt++; if (busy !== 1'b0) $display("FAIL sub_idle got %b exp 0", busy); else pass_cnt++;
    total_cnt++; if (dp_sel !== 1'b1) $display("FAIL sub_sel_hold got %b exp 1", dp_sel); else pass_cnt++;
    total_cnt++; if (dp_op !== 1'b1) $display("FAIL sub_op_hold got %b exp 1", dp_op); else pass_cnt++;
    $display("subtract: id=%b result=%h", rsp_id, rsp_result);
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int r0 = 0;
    int r1 = 0;
    int last = 0;
    logic exp_id;
    res0 = 4'h3; res1 = 4'hC;
    req0_valid = 1'b1; req0_op = 1'b0; req1_valid = 1'b1; req1_op = 1'b1; rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
      tick();
      total_cnt++; if (req0_ready && req1_ready) $display("FAIL b2b_both_ready got 11 exp not both"); else pass_cnt++;
      if (req0_ready) r0++;
      if (req1_ready) r1++;
      if (rsp_valid) begin
        exp_id = (n % 2 == 1);
        total_cnt++; if (rsp_id !== exp_id) $display("FAIL b2b_rsp_id[%0d] got %b exp %b", n, rsp_id, exp_id); else pass_cnt++;
        total_cnt++; if (rsp_result !== (exp_id ? 4'hC : 4'h3)) $display("FAIL b2b_rsp_result[%0d] got %h exp %h", n, rsp_result, exp_id ? 4'hC : 4'h3); else pass_cnt++;
        if (n > 0) begin
          total_cnt++; if (cyc - last != SETTLE + 2) $display("FAIL b2b_spacing[%0d] got %0d exp %0d", n, cyc - last, SETTLE + 2); else pass_cnt++;
        end
        $display("back_to_back: rsp %0d id=%b result=%h", n, rsp_id, rsp_result);
        last = cyc;
        n++;
        if (n == 4) begin
          req0_valid = 1'b0; req1_valid = 1'b0;
        end
      end
    end
    total_cnt++; if (n != 4) $display("FAIL b2b_rsp_count got %0d exp 4", n); else pass_cnt++;
    total_cnt++; if (r0 != 2) $display("FAIL b2b_ready0_count got %0d exp 2", r0); else pass_cnt++;
    total_cnt++; if (r1 != 2) $display("FAIL b2b_ready1_count got %0d exp 2", r1); else pass_cnt++;
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    res0 = 4'h7; req0_valid = 1'b1; req0_op = 1'b0; rsp_ready = 1'b0;
    repeat (3) tick(); // cycle 3, first RESP cycle
    for (int i = 0; i < 5; i++) begin
      total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL bp_rsp_valid[%0d] got %b exp 1", i, rsp_valid); else pass_cnt++;
      total_cnt++; if (rsp_id !== 1'b0) $display("FAIL bp_rsp_id[%0d] got %b exp 0", i, rsp_id); else pass_cnt++;
      total_cnt++; if (rsp_result !== 4'h7) $display("FAIL bp_rsp_result[%0d] got %h exp 7", i, rsp_result); else pass_cnt++;
      total_cnt++; if (req0_ready !== 1'b0) $display("FAIL bp_no_grant[%0d] got %b exp 0", i, req0_ready); else pass_cnt++;
      tick();
    end
    total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL bp_rsp_still got %b exp 1", rsp_valid); else pass_cnt++;
    rsp_ready = 1'b1;
    tick(); // IDLE cycle after the handshake
    rsp_ready = 1'b0;
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL bp_release got %b exp 0", rsp_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL bp_idle_gap got %b exp 0", busy); else pass_cnt++;
    tick();
    total_cnt++; if (busy !== 1'b1) $display("FAIL bp_regrant got %b exp 1", busy); else pass_cnt++;
    tick();
    total_cnt++; if (req0_ready !== 1'b1) $display("FAIL bp_second_ready got %b exp 1", req0_ready); else pass_cnt++;
    tick();
    req0_valid = 1'b0; rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    $display("backpressure: held 5 cycles, regrant followed release");
  endtask

  task automatic test_reset_mid_settle();
    res1 = 4'h5; req1_valid = 1'b1; req1_op = 1'b1;
    tick(); // cycle 1
    rst_n = 1'b0;
    tick();
    total_cnt++; if (req0_ready !== 1'b0) $display("FAIL mid_req0_ready got %b exp 0", req0_ready); else pass_cnt++;
    total_cnt++; if (req1_ready !== 1'b0) $display("FAIL mid_req1_ready got %b exp 0", req1_ready); else pass_cnt++;
    total_cnt++; if (dp_sel !== 1'b0) $display("FAIL mid_dp_sel got %b exp 0", dp_sel); else pass_cnt++;
    total_cnt++; if (dp_op !== 1'b0) $display("FAIL mid_dp_op got %b exp 0", dp_op); else pass_cnt++;
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL mid_rsp_valid got %b exp 0", rsp_valid); else pass_cnt++;
    total_cnt++; if (rsp_result !== 4'h0) $display("FAIL mid_rsp_result got %h exp 0", rsp_result); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL mid_busy got %b exp 0", busy); else pass_cnt++;
    rst_n = 1'b1; req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total_cnt++; if (req0_ready || req1_ready || rsp_valid) $display("FAIL mid_quiet[%0d] got %b%b%b exp 000", i, req0_ready, req1_ready, rsp_valid); else pass_cnt++;
    end
    res0 = 4'h9; req0_valid = 1'b1; req0_op = 1'b0; req1_valid = 1'b1; req1_op = 1'b0; rsp_ready = 1'b1;
    tick();
    total_cnt++; if (dp_sel !== 1'b0) $display("FAIL mid_prio_sel got %b exp 0", dp_sel); else pass_cnt++;
    tick();
    total_cnt++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) $display("FAIL mid_prio_ready got %b%b exp 10", req0_ready, req1_ready); else pass_cnt++;
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    total_cnt++; if (rsp_id !== 1'b0) $display("FAIL mid_prio_id got %b exp 0", rsp_id); else pass_cnt++;
    total_cnt++; if (rsp_result !== 4'h9) $display("FAIL mid_prio_result got %h exp 9", rsp_result); else pass_cnt++;
    tick();
    rsp_ready = 1'b0;
    $display("reset_mid_settle: op discarded, requester 0 won contested grant");
  endtask

`ifdef MODADDSUB_CTRL_STATS_EN
  task automatic test_stats();
    int hs = 0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total_cnt++; if (stat0 !== 8'd0 || stat1 !== 8'd0) $display("FAIL stats_reset got %0d/%0d exp 0/0", stat0, stat1); else pass_cnt++;
    res0 = 4'h2; req0_valid = 1'b1; req0_op = 1'b0; rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 2000 && hs < 300; cyc++) begin
      tick();
      if (rsp_valid) begin
        if (hs == 100) begin
          total_cnt++; if (stat0 !== 8'd100) $display("FAIL stats_mid got %0d exp 100", stat0); else pass_cnt++;
        end
        hs++;
        if (hs == 300) req0_valid = 1'b0;
      end
    end
    tick();
    rsp_ready = 1'b0;
    total_cnt++; if (hs != 300) $display("FAIL stats_hs_count got %0d exp 300", hs); else pass_cnt++;
    total_cnt++; if (stat0 !== 8'd255) $display("FAIL stats_stat0 got %0d exp 255", stat0); else pass_cnt++;
    total_cnt++; if (stat1 !== 8'd0) $display("FAIL stats_stat1 got %0d exp 0", stat1); else pass_cnt++;
    $display("stats: %0d handshakes, stat0=%0d stat1=%0d", hs, stat0, stat1);
  endtask
`endif

  initial begin
    test_reset();
    test_single_add();
    test_subtract();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_settle();
`ifdef MODADDSUB_CTRL_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/modaddsub_ctrl.md
# modaddsub_ctrl

Sequencing controller and two-port arbiter for the shared modular adder/subtractor datapath. It grants one of two requesters at a time and drives the operand-mux select so the eight-way 2:1 operand mux routes that requester's bits. It also drives the add/sub operation, waits a fixed settle time for the combinational datapath, captures the result, and returns it with a tagged valid/ready response. Sits between the operand sources and the datapath, one level above the operand mux.

## Interface
- WIDTH, 4: operand/result width in bits; operands pass straight to the mux, not through this block.
- SETTLE, 2: cycles the datapath is given to settle after select/op change; legal range 1..15.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low; sampled on rising edge of clk
- req0_valid  in  1  requester 0 has an operation pending; a0/b0/op0 stable while high
- req0_op  in  1  requester 0 operation: 0 = add, 1 = subtract
- req0_ready  out  1  one-cycle accept pulse; the transfer completes when valid && ready
- req1_valid, req1_op, req1_ready  same as requester 0, for requester 1
- dp_sel  out  1  operand-mux select (s): 0 routes requester 0 operands, 1 routes requester 1
- dp_op  out  1  add/sub control to the datapath
- dp_result  in  WIDTH  combinational modular result from the datapath
- rsp_valid  out  1  response holding
- rsp_ready  in  1  consumer accepts the response
- rsp_id  out  1  requester that owns the response
- rsp_result  out  WIDTH  captured result
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, SETTLE, RESP. Reset state is IDLE.
- IDLE
  - If neither valid is high, hold.
  - If exactly one valid is high, grant that requester.
  - If both are high, grant the requester indicated by the round-robin pointer `prio`. `prio` resets to 0.
  - On grant: register dp_sel = grant and dp_op = that requester's op; load cnt = SETTLE-1; go to SETTLE.
- SETTLE
  - If cnt != 0, decrement cnt.
  - If cnt == 0: assert req<grant>_ready combinationally for this cycle only, capture dp_result into rsp_result and grant into rsp_id, then go to RESP.
- RESP
  - rsp_valid = 1.
  - On rsp_ready: set prio = ~grant and go to IDLE.
  - rsp_result and rsp_id hold stable until the handshake.
- dp_sel and dp_op hold their last values in IDLE and RESP. They change only on a grant.
- The controller performs no arithmetic; modular reduction belongs entirely to the datapath.
- A requester dropping valid before ready is a protocol violation. The controller does not abort; it still captures and responds. The bench must not do this.
- The ready pulse for the non-granted requester stays 0 throughout.

## Timing
- Reset values: req0_ready=0, req1_ready=0, dp_sel=0, dp_op=0, rsp_valid=0, rsp_id=0, rsp_result=0, busy=0, prio=0, cnt=0.
- Cycle of a grant in IDLE = cycle 0:
  - dp_sel/dp_op valid from cycle 1.
  - SETTLE occupies cycles 1..SETTLE.
  - req_ready pulses in cycle SETTLE.
  - rsp_valid first high in cycle SETTLE+1.
- Latency: grant to response is SETTLE+1 cycles (3 with default).
- If rsp_ready is high in the first RESP cycle, rsp_valid lasts exactly one cycle, then one IDLE cycle follows. Peak throughput is one operation per SETTLE+2 cycles.
- Backpressure: RESP holds indefinitely. New requests are not granted until the response is accepted.
- rst_n low at any edge, including mid-SETTLE or mid-RESP:
  - Next state is reset state and all outputs take their reset values.
  - The in-flight operation is discarded and no ready pulse is issued.

## Configuration
- MODADDSUB_CTRL_STATS_EN defined:
  - Adds outputs stat0 and stat1, 8 bits each.
  - Each is a per-requester count of completed response handshakes, saturating at 255.
  - Both reset to 0 and increment in the cycle rsp_valid && rsp_ready for the matching rsp_id.
- Not defined: the ports and counters do not exist; all other behaviour is identical.

## Test plan
- Single add on requester 0, with WIDTH=4, SETTLE=2 and the model driving dp_result=4'h1:
  - req0_valid=1, op=0 at cycle 0.
  - Expect dp_sel=0 and dp_op=0 from cycle 1, req0_ready pulse in cycle 2, and rsp_valid in cycle 3 with rsp_id=0, rsp_result=4'h1.
- Simultaneous requests: both valid held high continuously, rsp_ready=1.
  - Grants alternate 0,1,0,1.
  - rsp_id sequence is 0,1,0,1; each requester receives exactly one ready pulse per response.
- Subtract on requester 1 with the model driving dp_result=4'hE:
  - dp_sel=1 and dp_op=1 from cycle 1; rsp_result=4'hE, rsp_id=1.
- Backpressure:
  - Hold rsp_ready=0 for 5 cycles in RESP: rsp_valid, rsp_id and rsp_result stay stable and no new grant occurs even with req0_valid=1.
  - Release: the handshake completes, and the next grant comes one cycle later.
- Reset mid-SETTLE: rst_n=0 in cycle 1 of an operation.
  - All outputs are at reset values next cycle.
  - No req_ready pulse and no rsp_valid occur.
  - prio=0, so requester 0 wins the first contested grant after reset.
- With MODADDSUB_CTRL_STATS_EN defined, complete 300 requester-0 operations: stat0 saturates at 255 and stat1 stays 0.
